vis_accum: RTL and testbench
============================

Name: vis_accum

Overview:
- Downstream stage of the per-baseline visibility calculator.
- Consumes the short unsigned real/imag partial sums that stage emits and adds COUNT consecutive partials into wide accumulators.
- Emits one integrated visibility per frame to the visibility readout/buffer logic.
- Streaming, no backpressure, one baseline per instance.

Parameters:
- WIDTH, 4, width of input partials re_i/im_i (unsigned, offset-encoded: each sample contributes 0/1/2).
- ACCUM, 24, width of accumulators and re_o/im_o.
- COUNT, 256, number of partials integrated per frame; must be >= 1.
- PARTIAL, 8, samples represented by one input partial; used only for bias removal.

Ports:
- clock_i  input  1  system clock
- reset_i  input  1  asynchronous, active-high reset
- clear_i  input  1  synchronous frame restart; discards the partial frame
- valid_i  input  1  input beat valid
- last_i  input  1  partial-complete marker; word accepted only when valid_i & last_i
- re_i  input  WIDTH  real partial, unsigned
- im_i  input  WIDTH  imag partial, unsigned
- valid_o  output  1  one-cycle pulse; integrated frame present
- last_o  output  1  equals valid_o (frame boundary)
- re_o  output  ACCUM  integrated real
- im_o  output  ACCUM  integrated imag
- overflow_o  output  1  frame saturated; qualified by valid_o
- frame_o  output  16  frame sequence number of the emitted frame; wraps 65535->0

Behaviour:
- Reset: one clock, clock_i; reset is asynchronous and active-high (reset_i). Asserting reset_i clears all of the following: valid_o, last_o, overflow_o, re_o, im_o, frame_o, internal count, accumulators, sticky flags. Reset mid-frame discards that frame; the first accepted word after release starts frame 0.
- Accept: word accepted iff valid_i=1 and last_i=1. valid_i without last_i is an intermediate upstream beat and is ignored. No ready; every accepted word is consumed.
- Count: internal counter 0..COUNT-1.
  - count==0: accumulators load the word (re_acc=re_i, im_acc=im_i); overflow sticky is cleared.
  - Otherwise: accumulators add the word.
  - Both inputs are zero-extended to ACCUM.
- Saturation: if an addition exceeds 2^ACCUM-1, the accumulator holds all-ones and the overflow sticky is set. Each of re and im saturates independently; the sticky is shared. ACCUM >= WIDTH+clog2(COUNT) guarantees no saturation.
- Frame completion: the word accepted when count==COUNT-1 completes the frame. On the next clock edge (latency 1 cycle):
  - valid_o=last_o=1.
  - re_o/im_o = final sums including that word.
  - overflow_o = sticky including that word.
  - frame_o = current frame number.
  - Then the frame counter increments and count returns to 0.
- Outputs: valid_o is high for exactly one cycle. re_o/im_o/frame_o/overflow_o hold their values until the next emission.
- Back-to-back: a word accepted in the cycle immediately after completion starts the new frame with no dead cycle. COUNT=1 emits every accepted word.
- clear_i:
  - Count is forced to 0 and the partial frame is discarded without output; frame_o is not incremented.
  - If a word is accepted in the same cycle, it becomes word 0 of a fresh frame.
  - If clear_i coincides with the completing word, the frame is discarded and valid_o stays 0.
- Idle gaps: gaps of any length between accepted words do not affect the sums.

Optional Feature:
- Macro VIS_ACCUM_SIGNED_EN.
- Defined: re_o/im_o are two's-complement signed values equal to the raw sum minus COUNT*PARTIAL (offset removal, centering on zero). The bias is subtracted in the output register stage, so latency is unchanged. On saturation the output is 2^(ACCUM-1)-1 and overflow_o=1.
- Undefined: re_o/im_o are the raw unsigned sums; no subtractor is built.

Test Plan:
- WIDTH=4, ACCUM=12, COUNT=4: accept re 3,5,7,9 and im 1,2,3,4 -> one cycle after the 4th word, valid_o=last_o=1, re_o=24, im_o=10, overflow_o=0, frame_o=0.
- Same config with VIS_ACCUM_SIGNED_EN, PARTIAL=8: same stimulus -> re_o=-8 (0xFF8), im_o=-22 (0xFEA).
- ACCUM=6, COUNT=8: eight words of re=15, im=1 -> re_o=63 (saturated), im_o=8, overflow_o=1. The next frame of all-1 words -> re_o=8, overflow_o=0.
- COUNT=4: eight consecutive accepted words, no gaps -> two valid_o pulses 4 cycles apart with frame_o=0 then 1. Beats with valid_i=1, last_i=0 inserted between words do not change the sums.
- COUNT=4: two words accepted, then clear_i together with a word of re=2, then three more words of re=1 -> one valid_o with re_o=5, frame_o=0.
- Assert reset_i asynchronously after 3 of 4 words -> all outputs 0 immediately. After release, 4 words of re=1 -> re_o=4, frame_o=0.

Source files
------------

// File: rtl/vis_accum_if.sv
// vis_accum_if: partial-sum stream in, integrated visibility out.
// slave = accumulator side, master = upstream/readout side.
interface vis_accum_if #(
  parameter int WIDTH = 4,
  parameter int ACCUM = 24
);
  logic             clear_i;
  logic             valid_i;
  logic             last_i;
  logic [WIDTH-1:0] re_i;
  logic [WIDTH-1:0] im_i;
  logic             valid_o;
  logic             last_o;
  logic [ACCUM-1:0] re_o;
  logic [ACCUM-1:0] im_o;
  logic             overflow_o;
  logic [15:0]      frame_o;

  modport slave (
    input  clear_i, valid_i, last_i, re_i, im_i,
    output valid_o, last_o, re_o, im_o, overflow_o, frame_o
  );

  modport master (
    output clear_i, valid_i, last_i, re_i, im_i,
    input  valid_o, last_o, re_o, im_o, overflow_o, frame_o
  );
endinterface

// File: rtl/vis_accum.sv
// vis_accum: integrates COUNT re/im partials per frame into saturating
// wide accumulators and emits one registered visibility per frame.
// Ports: clock_i, reset_i (async, active-high), bus (vis_accum_if.slave):
//   clear_i/valid_i/last_i/re_i/im_i in; valid_o/last_o/re_o/im_o/
//   overflow_o/frame_o out.
// Option: define VIS_ACCUM_SIGNED_EN to emit bias-removed signed sums.
module vis_accum #(
  parameter int WIDTH   = 4,
  parameter int ACCUM   = 24,
  parameter int COUNT   = 256,
  parameter int PARTIAL = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  vis_accum_if.slave  bus
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0]    LAST = CW'(COUNT - 1);
  localparam logic [ACCUM-1:0] ONES = {ACCUM{1'b1}};

  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic [ACCUM-1:0] re_acc_q, re_acc_d;
  logic [ACCUM-1:0] im_acc_q, im_acc_d;
  logic [ACCUM-1:0] re_base, im_base;
  logic [ACCUM:0]   re_sum, im_sum;
  logic             re_sat_q, re_sat_d;
  logic             im_sat_q, im_sat_d;
  logic             take, first, done;
  logic [15:0]      frame_q;

  logic             valid_q;
  logic [ACCUM-1:0] re_o_q, re_o_d;
  logic [ACCUM-1:0] im_o_q, im_o_d;
  logic             ovf_q;
  logic [15:0]      frame_o_q;

`ifdef VIS_ACCUM_SIGNED_EN
  localparam logic [ACCUM-1:0] BIAS = ACCUM'(COUNT * PARTIAL);
  localparam logic [ACCUM-1:0] SMAX = {1'b0, {(ACCUM-1){1'b1}}};
`endif

  always_comb begin
    take     = bus.valid_i & bus.last_i;
    // clear restarts the frame; a word in the same cycle becomes word 0
    cnt_base = bus.clear_i ? '0 : cnt_q;
    first    = (cnt_base == '0);
    re_base  = first ? '0 : re_acc_q;
    im_base  = first ? '0 : im_acc_q;
    re_sum   = {1'b0, re_base}
             + {{(ACCUM+1-WIDTH){1'b0}}, bus.re_i};
    im_sum   = {1'b0, im_base}
             + {{(ACCUM+1-WIDTH){1'b0}}, bus.im_i};
    // all-ones stays all-ones: any further carry re-saturates
    re_acc_d = re_sum[ACCUM] ? ONES : re_sum[ACCUM-1:0];
    im_acc_d = im_sum[ACCUM] ? ONES : im_sum[ACCUM-1:0];
    re_sat_d = (first ? 1'b0 : re_sat_q) | re_sum[ACCUM];
    im_sat_d = (first ? 1'b0 : im_sat_q) | im_sum[ACCUM];
    done     = take & (cnt_base == LAST);
    if (done)      cnt_d = '0;
    else if (take) cnt_d = cnt_base + 1'b1;
    else           cnt_d = cnt_base;
`ifdef VIS_ACCUM_SIGNED_EN
    re_o_d = re_sat_d ? SMAX : re_acc_d - BIAS;
    im_o_d = im_sat_d ? SMAX : im_acc_d - BIAS;
`else
    re_o_d = re_acc_d;
    im_o_d = im_acc_d;
`endif
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      re_acc_q  <= '0;
      im_acc_q  <= '0;
      re_sat_q  <= 1'b0;
      im_sat_q  <= 1'b0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      re_o_q    <= '0;
      im_o_q    <= '0;
      ovf_q     <= 1'b0;
      frame_o_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= done;
      if (take) begin
        re_acc_q <= re_acc_d;
        im_acc_q <= im_acc_d;
        re_sat_q <= re_sat_d;
        im_sat_q <= im_sat_d;
      end
      if (done) begin
        re_o_q    <= re_o_d;
        im_o_q    <= im_o_d;
        ovf_q     <= re_sat_d | im_sat_d;
        frame_o_q <= frame_q;
        frame_q   <= frame_q + 16'd1;
      end
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.last_o     = valid_q;
  assign bus.re_o       = re_o_q;
  assign bus.im_o       = im_o_q;
  assign bus.overflow_o = ovf_q;
  assign bus.frame_o    = frame_o_q;

endmodule

// File: tb/tb_vis_accum.sv
// tb_vis_accum: two vis_accum instances (A: ACCUM=12 COUNT=4,
// B: ACCUM=6 COUNT=8) checked against a frame-level sum model.
module tb_vis_accum;
  localparam int WA = 4;
  localparam int AA = 12;
  localparam int CA = 4;
  localparam int AB = 6;
  localparam int CB = 8;
  localparam int P  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   run = 1'b0;
  always #5 clk = ~clk;

  vis_accum_if #(.WIDTH(WA), .ACCUM(AA)) ifa ();
  vis_accum_if #(.WIDTH(WA), .ACCUM(AB)) ifb ();

  vis_accum #(.WIDTH(WA), .ACCUM(AA), .COUNT(CA), .PARTIAL(P))
    dut_a (.clock_i(clk), .reset_i(rst), .bus(ifa));
  vis_accum #(.WIDTH(WA), .ACCUM(AB), .COUNT(CB), .PARTIAL(P))
    dut_b (.clock_i(clk), .reset_i(rst), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endfunction

  // frame-level model: sum the accepted words, clamp at the end
  int cfg_cnt [2] = '{CA, CB};
  int cfg_acc [2] = '{AA, AB};
  int m_cnt [2];
  int m_re  [2];
  int m_im  [2];
  int m_fr  [2];
  int e_v   [2];
  int e_re  [2];
  int e_im  [2];
  int e_ov  [2];
  int e_fr  [2];

  function automatic int out_of(int total, int acc, int cnt);
    int mx;
    mx = (1 << acc) - 1;
`ifdef VIS_ACCUM_SIGNED_EN
    if (total > mx) return (1 << (acc - 1)) - 1;
    return (total - cnt * P) & mx;
`else
    return (total > mx) ? mx : total;
`endif
  endfunction

  task automatic mstep(int k, logic v, logic l, logic c,
                       int re, int im);
    int mx;
    mx = (1 << cfg_acc[k]) - 1;
    e_v[k] = 0;
    if (c) begin
      m_cnt[k] = 0; m_re[k] = 0; m_im[k] = 0;
    end
    if (v && l) begin
      m_re[k] += re;
      m_im[k] += im;
      m_cnt[k]++;
      if (m_cnt[k] == cfg_cnt[k]) begin
        e_v[k]  = 1;
        e_re[k] = out_of(m_re[k], cfg_acc[k], cfg_cnt[k]);
        e_im[k] = out_of(m_im[k], cfg_acc[k], cfg_cnt[k]);
        e_ov[k] = ((m_re[k] > mx) || (m_im[k] > mx)) ? 1 : 0;
        e_fr[k] = m_fr[k];
        m_fr[k] = (m_fr[k] + 1) & 65535;
        m_cnt[k] = 0; m_re[k] = 0; m_im[k] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_re[k] = 0; m_im[k] = 0; m_fr[k] = 0;
        e_v[k] = 0; e_re[k] = 0; e_im[k] = 0;
        e_ov[k] = 0; e_fr[k] = 0;
      end
    end else begin
      mstep(0, ifa.valid_i, ifa.last_i, ifa.clear_i,
            int'(ifa.re_i), int'(ifa.im_i));
      mstep(1, ifb.valid_i, ifb.last_i, ifb.clear_i,
            int'(ifb.re_i), int'(ifb.im_i));
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("a_valid", int'(ifa.valid_o), e_v[0]);
      chk("a_last",  int'(ifa.last_o),  e_v[0]);
      chk("a_re",    int'(ifa.re_o),    e_re[0]);
      chk("a_im",    int'(ifa.im_o),    e_im[0]);
      chk("a_ovf",   int'(ifa.overflow_o), e_ov[0]);
      chk("a_frame", int'(ifa.frame_o), e_fr[0]);
      chk("b_valid", int'(ifb.valid_o), e_v[1]);
      chk("b_last",  int'(ifb.last_o),  e_v[1]);
      chk("b_re",    int'(ifb.re_o),    e_re[1]);
      chk("b_im",    int'(ifb.im_o),    e_im[1]);
      chk("b_ovf",   int'(ifb.overflow_o), e_ov[1]);
      chk("b_frame", int'(ifb.frame_o), e_fr[1]);
    end
  end

  task automatic beat(int k, bit v, bit l, bit c, int re, int im);
    if (k == 0) begin
      ifa.valid_i = v; ifa.last_i = l; ifa.clear_i = c;
      ifa.re_i = 4'(re); ifa.im_i = 4'(im);
    end else begin
      ifb.valid_i = v; ifb.last_i = l; ifb.clear_i = c;
      ifb.re_i = 4'(re); ifb.im_i = 4'(im);
    end
    @(posedge clk);
    #1;
    if (k == 0) begin
      ifa.valid_i = 0; ifa.last_i = 0; ifa.clear_i = 0;
    end else begin
      ifb.valid_i = 0; ifb.last_i = 0; ifb.clear_i = 0;
    end
  endtask

  task automatic word(int k, int re, int im);
    beat(k, 1, 1, 0, re, im);
  endtask

  task automatic lit_a(string n, int re, int im, int ov, int fr);
    chk({n, "_valid"}, int'(ifa.valid_o), 1);
    chk({n, "_last"},  int'(ifa.last_o), 1);
    chk({n, "_re"},    int'(ifa.re_o), re);
    chk({n, "_im"},    int'(ifa.im_o), im);
    chk({n, "_ovf"},   int'(ifa.overflow_o), ov);
    chk({n, "_frame"}, int'(ifa.frame_o), fr);
    chk({n, "_model_re"}, e_re[0], re);
  endtask

  task automatic lit_b(string n, int re, int im, int ov, int fr);
    chk({n, "_valid"}, int'(ifb.valid_o), 1);
    chk({n, "_re"},    int'(ifb.re_o), re);
    chk({n, "_im"},    int'(ifb.im_o), im);
    chk({n, "_ovf"},   int'(ifb.overflow_o), ov);
    chk({n, "_frame"}, int'(ifb.frame_o), fr);
    chk({n, "_model_re"}, e_re[1], re);
  endtask

`ifdef VIS_ACCUM_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  initial begin
    ifa.valid_i = 0; ifa.last_i = 0; ifa.clear_i = 0;
    ifa.re_i = 0; ifa.im_i = 0;
    ifb.valid_i = 0; ifb.last_i = 0; ifb.clear_i = 0;
    ifb.re_i = 0; ifb.im_i = 0;
    #1 rst = 1;
    run = 1;
    #1;
    chk("rst_a_valid", int'(ifa.valid_o), 0);
    chk("rst_a_re",    int'(ifa.re_o), 0);
    chk("rst_a_frame", int'(ifa.frame_o), 0);
    chk("rst_b_ovf",   int'(ifb.overflow_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // basic frame with idle gaps
    word(0, 3, 1);
    beat(0, 0, 0, 0, 0, 0);
    word(0, 5, 2);
    word(0, 7, 3);
    beat(0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 0, 0);
    word(0, 9, 4);
    lit_a("basic", SG ? 4088 : 24, SG ? 4074 : 10, 0, 0);
    beat(0, 0, 0, 0, 0, 0);
    chk("pulse_one_cycle", int'(ifa.valid_o), 0);

    // back-to-back frames
    for (int i = 0; i < 8; i++) begin
      word(0, 1, 2);
      if (i == 3) lit_a("b2b0", SG ? 4068 : 4, SG ? 4072 : 8, 0, 1);
      if (i == 4) chk("b2b_gap", int'(ifa.valid_o), 0);
      if (i == 7) lit_a("b2b1", SG ? 4068 : 4, SG ? 4072 : 8, 0, 2);
    end

    // intermediate beats (valid without last) are ignored
    word(0, 2, 0);
    beat(0, 1, 0, 0, 15, 15);
    word(0, 2, 0);
    beat(0, 1, 0, 0, 15, 15);
    word(0, 2, 0);
    word(0, 2, 0);
    lit_a("filler", SG ? 4072 : 8, SG ? 4064 : 0, 0, 3);

    // clear together with a word restarts the frame
    word(0, 1, 0);
    word(0, 1, 0);
    beat(0, 1, 1, 1, 2, 0);
    word(0, 1, 0);
    word(0, 1, 0);
    word(0, 1, 0);
    lit_a("clear", SG ? 4069 : 5, SG ? 4064 : 0, 0, 4);

    // clear on the completing word discards the frame
    word(0, 1, 0);
    word(0, 1, 0);
    word(0, 1, 0);
    beat(0, 1, 1, 1, 4, 0);
    chk("clear_last_no_pulse", int'(ifa.valid_o), 0);
    word(0, 1, 0);
    word(0, 1, 0);
    word(0, 1, 0);
    lit_a("clear_last", SG ? 4071 : 7, SG ? 4064 : 0, 0, 5);

    // saturation on instance B, then a clean frame
    for (int i = 0; i < 8; i++) word(1, 15, 1);
    lit_b("sat", SG ? 31 : 63, 8, 1, 0);
    for (int i = 0; i < 8; i++) word(1, 1, 1);
    lit_b("unsat", 8, 8, 0, 1);

    // asynchronous reset mid-frame
    word(0, 1, 1);
    word(0, 1, 1);
    word(0, 1, 1);
    rst = 1;
    #1;
    chk("arst_valid", int'(ifa.valid_o), 0);
    chk("arst_re",    int'(ifa.re_o), 0);
    chk("arst_im",    int'(ifa.im_o), 0);
    chk("arst_ovf",   int'(ifb.overflow_o), 0);
    chk("arst_frame", int'(ifa.frame_o), 0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) word(0, 1, 0);
    lit_a("post_rst", SG ? 4068 : 4, SG ? 4064 : 0, 0, 0);

    beat(0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
